// File: rtl/lsu_mem_if.sv
// Load/store memory interface stage: accepts one load or store from execute,
// checks alignment/legality, issues a word-aligned DMEM request with byte mask
// and lane-shifted store data, and hands raw load words to the format stage.
module lsu_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_data,
  output logic [1:0]        ld_offset,
  output logic [2:0]        ld_sel,
  output logic              st_done,
  output logic              err,
  output logic              stall
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          off_q, off_d;
  logic                mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]          mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                ld_valid_q, ld_valid_d;
  logic [DATA_W-1:0]   ld_data_q, ld_data_d;
  logic [1:0]          ld_offset_q, ld_offset_d;
  logic [2:0]          ld_sel_q, ld_sel_d;
  logic                st_done_q, st_done_d;
  logic                err_q, err_d;

  // Misaligned halfword/word, reserved funct3, or unsigned-load codes on a store.
  function automatic logic op_legal(input logic we, input logic [2:0] f3,
                                    input logic [1:0] off);
    case (f3)
      3'b000:  op_legal = 1'b1;
      3'b001:  op_legal = !off[0];
      3'b010:  op_legal = (off == 2'b00);
      3'b100:  op_legal = !we;
      3'b101:  op_legal = !we && !off[0];
      default: op_legal = 1'b0;
    endcase
  endfunction

  // funct3 to the dense load-format code used downstream.
  function automatic logic [2:0] sel_of(input logic [2:0] f3);
    case (f3)
      3'b001:  sel_of = 3'd1;
      3'b010:  sel_of = 3'd2;
      3'b100:  sel_of = 3'd3;
      3'b101:  sel_of = 3'd4;
      default: sel_of = 3'd0;
    endcase
  endfunction

  // Next-state and next-output logic for the IDLE/ISSUE/WAIT_RSP sequence.
  always_comb begin
    // NOTE: every _d defaults to its _q (pulses to 0) before the case, so no latch is inferred.
    state_d         = state_q;
    we_d            = we_q;
    funct3_d        = funct3_q;
    off_d           = off_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_addr_d      = mem_addr_q;
    mem_we_d        = mem_we_q;
    mem_wdata_d     = mem_wdata_q;
    ld_valid_d      = 1'b0;
    ld_data_d       = ld_data_q;
    ld_offset_d     = ld_offset_q;
    ld_sel_d        = ld_sel_q;
    st_done_d       = 1'b0;
    err_d           = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!op_legal(req_we, req_funct3, req_addr[1:0])) begin
            err_d = 1'b1;
          end else begin
            state_d         = ISSUE;
            we_d            = req_we;
            funct3_d        = req_funct3;
            off_d           = req_addr[1:0];
            mem_req_valid_d = 1'b1;
            mem_addr_d      = {req_addr[ADDR_W-1:2], 2'b00};
            mem_we_d        = 4'b0000;
            mem_wdata_d     = req_wdata;
            if (req_we) begin
              case (req_funct3)
                3'b000: begin
                  mem_we_d    = 4'b0001 << req_addr[1:0];
                  mem_wdata_d = {4{req_wdata[7:0]}};
                end
                3'b001: begin
                  mem_we_d    = 4'b0011 << req_addr[1:0];
                  mem_wdata_d = {2{req_wdata[15:0]}};
                end
                default: mem_we_d = 4'b1111;
              endcase
            end
          end
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          if (we_q) begin
            st_done_d = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          ld_valid_d  = 1'b1;
          ld_data_d   = mem_rsp_data;
          ld_offset_d = off_q;
          ld_sel_d    = sel_of(funct3_q);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      we_q            <= 1'b0;
      funct3_q        <= 3'b000;
      off_q           <= 2'b00;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_we_q        <= 4'b0000;
      mem_wdata_q     <= '0;
      ld_valid_q      <= 1'b0;
      ld_data_q       <= '0;
      ld_offset_q     <= 2'b00;
      ld_sel_q        <= 3'b000;
      st_done_q       <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values and updates together.
      state_q         <= state_d;
      we_q            <= we_d;
      funct3_q        <= funct3_d;
      off_q           <= off_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      mem_we_q        <= mem_we_d;
      mem_wdata_q     <= mem_wdata_d;
      ld_valid_q      <= ld_valid_d;
      ld_data_q       <= ld_data_d;
      ld_offset_q     <= ld_offset_d;
      ld_sel_q        <= ld_sel_d;
      st_done_q       <= st_done_d;
      err_q           <= err_d;
    end
  end

  assign stall         = (state_q != IDLE);
  assign req_ready     = !stall;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_we        = mem_we_q;
  assign mem_wdata     = mem_wdata_q;
  assign ld_valid      = ld_valid_q;
  assign ld_data       = ld_data_q;
  assign ld_offset     = ld_offset_q;
  assign ld_sel        = ld_sel_q;
  assign st_done       = st_done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if: inputs change and outputs are sampled 1ns
// after each rising edge.
module tb_lsu_mem_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_we;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        ld_valid, st_done, err, stall;
  logic [31:0] ld_data;
  logic [1:0]  ld_offset;
  logic [2:0]  ld_sel;

  int total = 0;
  int bad   = 0;
  int n_ld  = 0;
  int n_st  = 0;

  always #5 clk = ~clk;

  lsu_mem_if #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_offset(ld_offset), .ld_sel(ld_sel),
    .st_done(st_done), .err(err), .stall(stall)
  );

  // Pulse counting and mutual-exclusion watch on the falling edge.
  always @(negedge clk) begin
    if (ld_valid === 1'b1) n_ld++;
    if (st_done === 1'b1) n_st++;
    if ((ld_valid | st_done | err) === 1'b1) begin
      total++;
      if ($countones({ld_valid, st_done, err}) > 1) begin
        bad++;
        $display("FAIL pulse_exclusive got ld=%0b st=%0b err=%0b exp one-hot", ld_valid, st_done, err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = '0;
    req_wdata = '0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    #12;
    total++; if ({mem_req_valid, mem_addr, mem_we, mem_wdata} !== 69'd0) begin bad++; $display("FAIL reset_mem got v=%0b a=%h we=%b wd=%h exp all 0", mem_req_valid, mem_addr, mem_we, mem_wdata); end
    total++; if ({ld_valid, ld_data, ld_offset, ld_sel, st_done, err} !== 40'd0) begin bad++; $display("FAIL reset_ld got ldv=%0b d=%h o=%0d s=%0d st=%0b err=%0b exp all 0", ld_valid, ld_data, ld_offset, ld_sel, st_done, err); end
    total++; if (stall !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got stall=%0b ready=%0b exp 0/1", stall, req_ready); end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lw();
    drive_req(1'b0, 3'b010, 32'h1000, 32'h0);
    mem_req_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    total++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h1000 || mem_we !== 4'b0000) begin bad++; $display("FAIL lw_issue got v=%0b a=%h we=%b exp 1/00001000/0000", mem_req_valid, mem_addr, mem_we); end
    total++; if (stall !== 1'b1 || req_ready !== 1'b0) begin bad++; $display("FAIL lw_stall got stall=%0b ready=%0b exp 1/0", stall, req_ready); end
    tick();
    total++; if (mem_req_valid !== 1'b0 || ld_valid !== 1'b0) begin bad++; $display("FAIL lw_wait got v=%0b ldv=%0b exp 0/0", mem_req_valid, ld_valid); end
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF;
    tick();
    mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    total++; if (ld_valid !== 1'b1 || ld_data !== 32'hDEADBEEF || ld_offset !== 2'd0 || ld_sel !== 3'd2) begin bad++; $display("FAIL lw_result got v=%0b d=%h o=%0d s=%0d exp 1/deadbeef/0/2", ld_valid, ld_data, ld_offset, ld_sel); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lw_idle got stall=%0b exp 0", stall); end
    tick();
    total++; if (ld_valid !== 1'b0 || ld_data !== 32'hDEADBEEF || ld_sel !== 3'd2) begin bad++; $display("FAIL lw_hold got v=%0b d=%h s=%0d exp 0/deadbeef/2", ld_valid, ld_data, ld_sel); end
  endtask

  task automatic test_store();
    logic [31:0] addr_v [2] = '{32'h2003, 32'h2002};
    logic [2:0]  f3_v   [2] = '{3'b000, 3'b001};
    logic [31:0] wd_v   [2] = '{32'h000000A5, 32'h00001234};
    logic [3:0]  we_x   [2] = '{4'b1000, 4'b1100};
    logic [31:0] wd_x   [2] = '{32'hA5A5A5A5, 32'h12341234};
    for (int i = 0; i < 2; i++) begin
      drive_req(1'b1, f3_v[i], addr_v[i], wd_v[i]);
      tick();
      req_valid = 1'b0;
      total++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h2000 || mem_we !== we_x[i] || mem_wdata !== wd_x[i]) begin bad++; $display("FAIL st_issue[%0d] got v=%0b a=%h we=%b wd=%h exp 1/00002000/%b/%h", i, mem_req_valid, mem_addr, mem_we, mem_wdata, we_x[i], wd_x[i]); end
      tick();
      total++; if (st_done !== 1'b1 || mem_req_valid !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL st_done[%0d] got st=%0b v=%0b stall=%0b exp 1/0/0", i, st_done, mem_req_valid, stall); end
      tick();
      total++; if (st_done !== 1'b0) begin bad++; $display("FAIL st_once[%0d] got st=%0b exp 0", i, st_done); end
    end
  endtask

  task automatic test_err();
    logic        we_v   [3] = '{1'b0, 1'b1, 1'b1};
    logic [2:0]  f3_v   [3] = '{3'b101, 3'b010, 3'b100};
    logic [31:0] addr_v [3] = '{32'h3001, 32'h3002, 32'h3000};
    for (int i = 0; i < 3; i++) begin
      drive_req(we_v[i], f3_v[i], addr_v[i], 32'h55);
      tick();
      req_valid = 1'b0;
      total++; if (err !== 1'b1 || mem_req_valid !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL err_pulse[%0d] got err=%0b v=%0b stall=%0b exp 1/0/0", i, err, mem_req_valid, stall); end
      tick();
      total++; if (err !== 1'b0 || mem_req_valid !== 1'b0) begin bad++; $display("FAIL err_once[%0d] got err=%0b v=%0b exp 0/0", i, err, mem_req_valid); end
    end
  endtask

  task automatic test_wait_states();
    drive_req(1'b0, 3'b100, 32'h4002, 32'h0);
    mem_req_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h4000 || mem_we !== 4'b0000 || stall !== 1'b1) begin bad++; $display("FAIL lbu_hold[%0d] got v=%0b a=%h we=%b stall=%0b exp 1/00004000/0000/1", i, mem_req_valid, mem_addr, mem_we, stall); end
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      total++; if (stall !== 1'b1 || ld_valid !== 1'b0 || mem_req_valid !== 1'b0) begin bad++; $display("FAIL lbu_wait[%0d] got stall=%0b ldv=%0b v=%0b exp 1/0/0", i, stall, ld_valid, mem_req_valid); end
      if (i == 1) begin mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00C30000; end
      tick();
    end
    mem_rsp_valid = 1'b0;
    total++; if (ld_valid !== 1'b1 || ld_sel !== 3'd3 || ld_offset !== 2'd2 || ld_data !== 32'h00C30000) begin bad++; $display("FAIL lbu_result got v=%0b s=%0d o=%0d d=%h exp 1/3/2/00c30000", ld_valid, ld_sel, ld_offset, ld_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    drive_req(1'b0, 3'b010, 32'h7004, 32'h0);
    tick();
    req_valid = 1'b0;
    tick();
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rst_mid_pre got stall=%0b exp 1", stall); end
    rst_n = 1'b0;
    #1;
    total++; if ({mem_req_valid, mem_addr, mem_we, mem_wdata, ld_valid, ld_data, ld_offset, ld_sel, st_done, err, stall} !== 110'd0) begin bad++; $display("FAIL rst_mid_zero got v=%0b a=%h ld=%h stall=%0b exp all 0", mem_req_valid, mem_addr, ld_data, stall); end
    tick();
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0BAD0;
    tick();
    mem_rsp_valid = 1'b0;
    tick();
    total++; if (ld_valid !== 1'b0 || ld_data !== 32'h0 || stall !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_late got ldv=%0b d=%h stall=%0b ready=%0b exp 0/0/0/1", ld_valid, ld_data, stall, req_ready); end
  endtask

  task automatic test_back_to_back();
    int ld0, st0;
    ld0 = n_ld; st0 = n_st;
    drive_req(1'b0, 3'b010, 32'h5000, 32'h0);
    mem_req_ready = 1'b1;
    tick();
    drive_req(1'b1, 3'b010, 32'h6000, 32'hCAFEF00D);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_busy got ready=%0b exp 0", req_ready); end
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h11223344;
    tick();
    mem_rsp_valid = 1'b0;
    total++; if (ld_valid !== 1'b1 || req_ready !== 1'b1 || ld_data !== 32'h11223344) begin bad++; $display("FAIL b2b_ld got ldv=%0b ready=%0b d=%h exp 1/1/11223344", ld_valid, req_ready, ld_data); end
    tick();
    req_valid = 1'b0;
    total++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h6000 || mem_we !== 4'b1111 || mem_wdata !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_sw got v=%0b a=%h we=%b wd=%h exp 1/00006000/1111/cafef00d", mem_req_valid, mem_addr, mem_we, mem_wdata); end
    tick();
    total++; if (st_done !== 1'b1) begin bad++; $display("FAIL b2b_st got st=%0b exp 1", st_done); end
    tick(); tick();
    total++; if (n_ld - ld0 != 1 || n_st - st0 != 1) begin bad++; $display("FAIL b2b_count got ld=%0d st=%0d exp 1/1", n_ld - ld0, n_st - st0); end
    total++; if (stall !== 1'b0 || mem_req_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got stall=%0b v=%0b exp 0/0", stall, mem_req_valid); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_store();
    test_err();
    test_wait_states();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store memory interface stage directly upstream of the load-format select stage in the RISC-V core.
- Accepts one load or store per request from the execute stage and checks alignment.
- Issues a word-aligned request with byte mask and lane-shifted store data to DMEM over a valid/ready channel.
- For loads, captures the returned word and presents raw word, byte offset and load-format select code to the downstream load-format stage. Stalls the pipeline while a transaction is outstanding.

Parameters:
- ADDR_W, 32, address width (word alignment drops bits [1:0])
- DATA_W, 32, data width; fixed at 32, 4 byte lanes

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents a memory op
- req_ready  out  1  block accepts op this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- mem_req_valid  out  1  DMEM request valid
- mem_req_ready  in  1  DMEM accepts request
- mem_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0
- mem_we  out  4  byte write mask; 0000 for loads
- mem_wdata  out  32  lane-shifted store data
- mem_rsp_valid  in  1  DMEM read data valid
- mem_rsp_data  in  32  DMEM read word
- ld_valid  out  1  one-cycle pulse: ld_data, ld_offset, ld_sel valid
- ld_data  out  32  raw read word
- ld_offset  out  2  req_addr[1:0] of the load
- ld_sel  out  3  load format: 0 B, 1 H, 2 W, 3 BU, 4 HU
- st_done  out  1  one-cycle pulse when a store is accepted by DMEM
- err  out  1  one-cycle pulse: misaligned or illegal op, no memory access
- stall  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE.
  - All registered outputs = 0: mem_req_valid, mem_addr, mem_we, mem_wdata, ld_*, st_done, err.
  - Any in-flight transaction is abandoned; a late mem_rsp_valid after reset is ignored (state is IDLE).
- FSM states: IDLE, ISSUE, WAIT_RSP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch we, funct3, addr and wdata, and run the legality check.
  - Illegal op: err = 1 next cycle, state stays IDLE, no DMEM request.
  - Legal op: go to ISSUE.
- Legality check:
  - H/HU with addr[0] = 1 is misaligned.
  - W with addr[1:0] != 0 is misaligned.
  - funct3 011, 110 or 111 is illegal.
  - Store with funct3 100 or 101 is illegal.
- ISSUE:
  - mem_req_valid = 1; mem_addr, mem_we and mem_wdata are held stable until mem_req_ready = 1.
  - On handshake, mem_req_valid drops the next cycle.
  - Store: st_done = 1 next cycle, state goes to IDLE.
  - Load: state goes to WAIT_RSP.
- WAIT_RSP:
  - On mem_rsp_valid, next cycle ld_valid = 1, ld_data = mem_rsp_data, ld_offset = addr[1:0], ld_sel = funct3 mapped (000→0, 001→1, 010→2, 100→3, 101→4). State goes to IDLE.
  - ld_data, ld_offset and ld_sel hold their values after the pulse until the next load completes.
  - mem_rsp_valid in IDLE or ISSUE is ignored; DMEM responds no earlier than the cycle after acceptance.
- Store lane shift, with off = addr[1:0]:
  - SB: mem_we = 4'b0001 << off; mem_wdata = {4{wdata[7:0]}}.
  - SH: mem_we = 4'b0011 << off; mem_wdata = {2{wdata[15:0]}}.
  - SW: mem_we = 4'b1111; mem_wdata = wdata.
- Pulses: ld_valid, st_done and err are each exactly one cycle. At most one is high in any cycle.
- stall: combinational, (state != IDLE). req_ready = !stall.
- Latency with zero-wait DMEM:
  - Load: ld_valid 3 cycles after req acceptance.
  - Store: st_done 2 cycles after req acceptance.
- Back-to-back: a new request may be accepted in the same cycle that ld_valid, st_done or err is high.

Test Plan:
- LW addr 0x1000, mem_rsp_data 0xDEADBEEF, zero wait → mem_addr 0x1000, mem_we 0000, ld_valid 3 cycles after accept, ld_data 0xDEADBEEF, ld_offset 0, ld_sel 2.
- SB addr 0x2003, wdata 0x000000A5 → mem_addr 0x2000, mem_we 1000, mem_wdata 0xA5A5A5A5, st_done once; SH addr 0x2002, wdata 0x1234 → mem_we 1100, mem_wdata 0x12341234.
- LHU addr 0x3001 → err pulse 1 cycle, mem_req_valid never asserted, stall stays 0; SW addr 0x3002 → err; store with funct3 100 → err.
- LBU addr 0x4002, mem_req_ready low 3 cycles, rsp 2 cycles later → mem_addr/mem_we stable while waiting, stall high throughout, ld_sel 3, ld_offset 2.
- rst_n low while in WAIT_RSP, then mem_rsp_valid arrives after release → all outputs 0, no ld_valid, state IDLE, req_ready 1.
- Back-to-back LW then SW with req_valid held high → second request accepted in the cycle ld_valid is high; no lost or duplicated pulses.
